// File: rtl/fetch_redirect_if.sv
// rtl/fetch_redirect_if.sv - redirect/fetch handshake bundle between MEM-stage resolve and IF-stage PC logic
interface fetch_redirect_if #(
  parameter int COUNT_W = 16
);
  logic               resolve_valid;
  logic [1:0]         resolve_kind;
  logic [15:0]        resolve_target;
  logic               stall;
  logic               fetch_ready;
  logic               pcmux_sel;
  logic               load_pc;
  logic [15:0]        redirect_pc;
  logic [1:0]         redirect_kind;
  logic               squash_if;
  logic               squash_id;
  logic               busy;
  logic               proto_err;
  logic [COUNT_W-1:0] redirect_count;

  modport master (
    output resolve_valid, resolve_kind, resolve_target, stall, fetch_ready,
    input  pcmux_sel, load_pc, redirect_pc, redirect_kind, squash_if, squash_id,
           busy, proto_err, redirect_count
  );

  modport slave (
    input  resolve_valid, resolve_kind, resolve_target, stall, fetch_ready,
    output pcmux_sel, load_pc, redirect_pc, redirect_kind, squash_if, squash_id,
           busy, proto_err, redirect_count
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - latches MEM-stage redirects, steers PC load and squashes wrong-path fetch
module fetch_redirect_unit #(
  parameter int DRAIN_CYCLES = 1,
  parameter int COUNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_redirect_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] DRAIN_INIT = 2'(DRAIN_CYCLES);

  state_t             state, state_nxt;
  logic [1:0]         dcnt, dcnt_nxt;
  logic [15:0]        target_q;
  logic [1:0]         kind_q;
  logic               perr_q;
  logic [COUNT_W-1:0] count_q;
  logic               capture;
  logic               fire;

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    capture   = 1'b0;
    fire      = 1'b0;
    case (state)
      S_IDLE: begin
        // A stalled event is not lost: the producer keeps it asserted.
        if (bus.resolve_valid && !bus.stall) begin
          capture   = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.fetch_ready && !bus.stall) begin
          fire      = 1'b1;
          dcnt_nxt  = DRAIN_INIT;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.stall) begin
          if (bus.resolve_valid) begin
            capture   = 1'b1;
            dcnt_nxt  = 2'd0;
            state_nxt = S_ISSUE;
          end else begin
            dcnt_nxt = dcnt - 2'd1;
            if (dcnt == 2'd1) begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dcnt_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      dcnt     <= 2'd0;
      target_q <= 16'h0000;
      kind_q   <= 2'b00;
      perr_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
      if (capture) begin
        target_q <= {bus.resolve_target[15:1], 1'b0};
        kind_q   <= bus.resolve_kind;
      end
      if (state == S_ISSUE && bus.resolve_valid) begin
        perr_q <= 1'b1;
      end
      if (fire && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  // Reset must suppress the strobe even while the state register still reads S_ISSUE.
  assign bus.load_pc        = fire && !reset;
  assign bus.pcmux_sel      = (state == S_ISSUE);
  assign bus.squash_if      = (state != S_IDLE);
  assign bus.squash_id      = (state == S_ISSUE);
  assign bus.busy           = (state != S_IDLE);
  assign bus.redirect_pc    = target_q;
  assign bus.redirect_kind  = kind_q;
  assign bus.proto_err      = perr_q;
  assign bus.redirect_count = count_q;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb/tb_fetch_redirect_unit.sv - scoreboard bench for fetch_redirect_unit with directed and random redirects
module tb_fetch_redirect_unit;
  localparam int D  = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_redirect_if #(.COUNT_W(CW)) bus ();

  fetch_redirect_unit #(.DRAIN_CYCLES(D), .COUNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0]   pc;
    logic [1:0]    kind;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  logic [CW-1:0] mdl_cnt;
  int            n_chk  = 0;
  int            n_fail = 0;
  logic          cnt_due = 1'b0;
  logic [CW-1:0] due_cnt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every load_pc must match the oldest captured redirect.
  always @(negedge clk) begin
    exp_t e;
    if (cnt_due) begin
      chk("count_after_load", 16'(bus.redirect_count), 16'(due_cnt));
      cnt_due = 1'b0;
    end
    if (bus.load_pc === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_load", 16'd1, 16'd0);
      end else begin
        e = q.pop_front();
        chk("load_pc_target", bus.redirect_pc, e.pc);
        chk("load_pc_kind", 16'(bus.redirect_kind), 16'(e.kind));
        chk("load_pc_pcmux", 16'(bus.pcmux_sel), 16'd1);
        chk("load_pc_squash_id", 16'(bus.squash_id), 16'd1);
        due_cnt = e.cnt;
        cnt_due = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] k, input logic [15:0] t);
    exp_t e;
    if (mdl_cnt != {CW{1'b1}}) mdl_cnt = mdl_cnt + 1'b1;
    e.pc   = t & 16'hFFFE;
    e.kind = k;
    e.cnt  = mdl_cnt;
    q.push_back(e);
  endtask

  task automatic issue(input logic [1:0] k, input logic [15:0] t, input logic fr);
    bus.resolve_valid  = 1'b1;
    bus.resolve_kind   = k;
    bus.resolve_target = t;
    bus.stall          = 1'b0;
    bus.fetch_ready    = fr;
    push_exp(k, t);
    tick();
    bus.resolve_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.resolve_valid  = 1'b0;
    bus.resolve_kind   = 2'b00;
    bus.resolve_target = 16'h0000;
    bus.stall          = 1'b0;
    bus.fetch_ready    = 1'b0;
    tick();
    reset   = 1'b0;
    q.delete();
    mdl_cnt = '0;
    cnt_due = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    bus.fetch_ready = 1'b1;
    bus.stall       = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) done = 1;
      else tick();
    end
    if (!done) chk("wait_idle_timeout", 16'd1, 16'd0);
  endtask

  initial begin
    int  rem;
    bit  st, fr, done;
    mdl_cnt = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_pcmux", 16'(bus.pcmux_sel), 16'd0);
    chk("rst_load", 16'(bus.load_pc), 16'd0);
    chk("rst_squash", 16'({bus.squash_if, bus.squash_id}), 16'd0);
    chk("rst_pc", bus.redirect_pc, 16'h0000);
    chk("rst_kind", 16'(bus.redirect_kind), 16'd0);
    chk("rst_count", 16'(bus.redirect_count), 16'd0);
    chk("rst_perr", 16'(bus.proto_err), 16'd0);

    // Basic BR redirect: load at N+1, squash for D cycles, idle at N+2+D
    tick();
    issue(2'b00, 16'h3005, 1'b1);
    @(negedge clk);
    chk("basic_load", 16'(bus.load_pc), 16'd1);
    chk("basic_pc", bus.redirect_pc, 16'h3004);
    chk("basic_squash_if", 16'(bus.squash_if), 16'd1);
    tick();
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("basic_drain_busy", 16'(bus.busy), 16'd1);
      chk("basic_drain_squash_if", 16'(bus.squash_if), 16'd1);
      chk("basic_drain_squash_id", 16'(bus.squash_id), 16'd0);
      chk("basic_drain_pcmux", 16'(bus.pcmux_sel), 16'd0);
      tick();
    end
    @(negedge clk);
    chk("basic_idle", 16'(bus.busy), 16'd0);
    chk("basic_count", 16'(bus.redirect_count), 16'd1);

    // Fetch backpressure
    tick();
    issue(2'b11, 16'h0400, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_pcmux", 16'(bus.pcmux_sel), 16'd1);
      chk("bp_load", 16'(bus.load_pc), 16'd0);
      tick();
    end
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    chk("bp_load_rise", 16'(bus.load_pc), 16'd1);
    tick();
    @(negedge clk);
    chk("bp_load_once", 16'(bus.load_pc), 16'd0);
    wait_idle();

    // Stall freeze in drain
    tick();
    issue(2'b00, 16'h1234, 1'b1);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_busy", 16'(bus.busy), 16'd1);
      chk("stall_squash_if", 16'(bus.squash_if), 16'd1);
      chk("stall_load", 16'(bus.load_pc), 16'd0);
      tick();
    end
    bus.stall = 1'b0;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("stall_resume_busy", 16'(bus.busy), 16'd1);
      tick();
    end
    @(negedge clk);
    chk("stall_exit", 16'(bus.busy), 16'd0);

    // Overlap: JSR then JMP arriving in drain
    do_reset();
    issue(2'b10, 16'h5000, 1'b1);
    tick();
    issue(2'b01, 16'h6000, 1'b1);
    @(negedge clk);
    chk("ovl_reissue", 16'(bus.pcmux_sel), 16'd1);
    chk("ovl_pc", bus.redirect_pc, 16'h6000);
    chk("ovl_kind", 16'(bus.redirect_kind), 16'd1);
    tick();
    @(negedge clk);
    chk("ovl_count", 16'(bus.redirect_count), 16'd2);
    wait_idle();

    // Protocol error: event in S_ISSUE is ignored but flagged
    tick();
    issue(2'b00, 16'h2222, 1'b0);
    bus.resolve_valid  = 1'b1;
    bus.resolve_kind   = 2'b11;
    bus.resolve_target = 16'h7777;
    tick();
    bus.resolve_valid  = 1'b0;
    @(negedge clk);
    chk("perr_set", 16'(bus.proto_err), 16'd1);
    chk("perr_pc_held", bus.redirect_pc, 16'h2222);
    chk("perr_kind_held", 16'(bus.redirect_kind), 16'd0);
    wait_idle();
    chk("perr_sticky", 16'(bus.proto_err), 16'd1);

    // Saturation then reset in S_ISSUE
    do_reset();
    for (int i = 0; i < 17; i++) begin
      issue(2'(i), 16'(16'h0100 + i * 3), 1'b1);
      wait_idle();
      tick();
    end
    @(negedge clk);
    chk("sat_count", 16'(bus.redirect_count), 16'hF);
    tick();
    issue(2'b11, 16'hABCD, 1'b0);
    reset = 1'b1;
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    chk("rst_cycle_load", 16'(bus.load_pc), 16'd0);
    tick();
    reset = 1'b0;
    q.delete();
    mdl_cnt = '0;
    @(negedge clk);
    chk("rst_mid_load", 16'(bus.load_pc), 16'd0);
    chk("rst_mid_busy", 16'(bus.busy), 16'd0);
    chk("rst_mid_squash", 16'({bus.squash_if, bus.squash_id, bus.pcmux_sel}), 16'd0);
    chk("rst_mid_pc", bus.redirect_pc, 16'h0000);
    chk("rst_mid_kind", 16'(bus.redirect_kind), 16'd0);
    chk("rst_mid_count", 16'(bus.redirect_count), 16'd0);
    chk("rst_mid_perr", 16'(bus.proto_err), 16'd0);
    tick();

    // Random: captures with held-through-stall, random fetch backpressure and gaps
    rem = 0;
    for (int it = 0; it < 60; it++) begin
      logic [1:0]  k;
      logic [15:0] t;
      k = 2'($urandom_range(0, 3));
      t = 16'($urandom);
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        st = ($urandom_range(0, 3) == 0);
        bus.resolve_valid  = 1'b1;
        bus.resolve_kind   = k;
        bus.resolve_target = t;
        bus.stall          = st;
        bus.fetch_ready    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rnd_cap_busy", 16'(bus.busy), 16'(rem > 0));
        if (!st) begin
          push_exp(k, t);
          done = 1;
        end
        tick();
      end
      if (!done) chk("rnd_cap_timeout", 16'd1, 16'd0);
      bus.resolve_valid = 1'b0;
      done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        fr = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 3) == 0);
        bus.fetch_ready = fr;
        bus.stall       = st;
        @(negedge clk);
        chk("rnd_load_timing", 16'(bus.load_pc), 16'(fr && !st));
        chk("rnd_issue_pcmux", 16'(bus.pcmux_sel), 16'd1);
        tick();
        if (fr && !st) done = 1;
      end
      if (!done) chk("rnd_load_timeout", 16'd1, 16'd0);
      rem = D;
      for (int g = $urandom_range(0, D + 2); g > 0; g--) begin
        st = ($urandom_range(0, 2) == 0);
        bus.stall       = st;
        bus.fetch_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("rnd_gap_busy", 16'(bus.busy), 16'(rem > 0));
        chk("rnd_gap_load", 16'(bus.load_pc), 16'd0);
        tick();
        if (!st && rem > 0) rem--;
      end
    end
    bus.stall = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("end_queue_empty", 16'(q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
